// File: rtl/note_scheduler.sv
// Note-table sequencer: advances song time on tick and issues each table entry
// as a valid/ready spawn once song time plus the lead time reaches its note time.
module note_scheduler #(
    parameter int NUM_NOTES = 5,
    parameter int TIME_W    = 21,
    parameter int LANE_W    = 11,
    parameter int LEN_W     = 3,
    parameter int LEAD_TIME = 0,
    localparam int IDX_W    = $clog2(NUM_NOTES + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              pause,
    input  logic                              tick,
    input  logic [NUM_NOTES-1:0][TIME_W-1:0]  note_time,
    input  logic [NUM_NOTES-1:0][LANE_W-1:0]  note_lane,
    input  logic [NUM_NOTES-1:0][LEN_W-1:0]   note_length,
    input  logic                              spawn_ready,
    output logic                              spawn_valid,
    output logic [LANE_W-1:0]                 spawn_lane,
    output logic [LEN_W-1:0]                  spawn_length,
    output logic [IDX_W-1:0]                  spawn_index,
    output logic [TIME_W-1:0]                 song_time,
    output logic                              busy,
    output logic                              done
);

    typedef enum logic [1:0] {IDLE, RUN, EMIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [TIME_W-1:0]   cur_time;
    logic [LANE_W-1:0]   cur_lane;
    logic [LEN_W-1:0]    cur_len;
    logic                at_end, due, restart, latch, xfer, adv;

    // Table read mux; the out-of-range index (idx == NUM_NOTES) reads zeros.
    always_comb begin
        cur_time = '0;
        cur_lane = '0;
        cur_len  = '0;
        for (int unsigned i = 0; i < unsigned'(NUM_NOTES); i++) begin
            if (idx == IDX_W'(i)) begin
                cur_time = note_time[i];
                cur_lane = note_lane[i];
                cur_len  = note_length[i];
            end
        end
    end

    assign at_end = (idx == IDX_W'(NUM_NOTES));
    assign due    = ({1'b0, song_time} + (TIME_W+1)'(LEAD_TIME)) >= {1'b0, cur_time};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        latch     = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    restart   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (at_end) begin
                    state_nxt = DONE;
                end else if (due) begin
                    latch     = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (spawn_ready) begin
                    xfer      = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign adv         = ((state == RUN) || (state == EMIT)) && tick && !pause;
    assign spawn_valid = (state == EMIT);
    assign busy        = (state == RUN) || (state == EMIT);
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            song_time    <= '0;
            spawn_lane   <= '0;
            spawn_length <= '0;
            spawn_index  <= '0;
        end else begin
            if (restart) begin
                idx       <= '0;
                song_time <= '0;
            end else begin
                if (adv && (song_time != '1)) song_time <= song_time + TIME_W'(1);
                if (xfer) idx <= idx + IDX_W'(1);
            end
            if (latch) begin
                spawn_lane   <= cur_lane;
                spawn_length <= cur_len;
                spawn_index  <= idx;
            end
        end
    end

endmodule
